// File: rtl/scan_sequencer.sv
// scan_sequencer: steps a 3-bit decoder select through the enabled channels, holding each channel for a programmable dwell.
module scan_sequencer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic               single_i,
  input  logic [7:0]         mask_i,
  input  logic [DWELL_W-1:0] dwell_i,
  output logic [2:0]         y_o,
  output logic               y_valid_o,
  output logic               busy_o,
  output logic               pass_done_o
);
  typedef enum logic {IDLE, DWELL} state_t;
  state_t state_q, state_d;
  logic [7:0] mask_q, mask_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d, cnt_q, cnt_d;
  logic single_q, single_d;
  logic [2:0] y_q, y_d;
  logic pass_q, pass_d;
  logic [3:0] first_i, next_q, after_d;
  // Lowest set bit of m at or above from; bit 3 flags that one was found.
  function automatic logic [3:0] find(input logic [7:0] m, input logic [3:0] from);
    find = '0;
    for (int i = 7; i >= 0; i--) if (m[i] && 4'(i) >= from) find = {1'b1, 3'(i)};
  endfunction
  // Dwell of 0 behaves as 1, so the counter reload never underflows.
  function automatic logic [DWELL_W-1:0] reload(input logic [DWELL_W-1:0] d);
    reload = (d == '0) ? '0 : d - DWELL_W'(1);
  endfunction
  assign first_i = find(mask_i, 4'd0);
  assign next_q  = find(mask_q, {1'b0, y_q} + 4'd1);
  assign after_d = find(mask_d, {1'b0, y_d} + 4'd1);
  // pass_done is registered one edge early: it is high in the cycle whose dwell ends with a wrap.
  assign pass_d = (state_d == DWELL) && (cnt_d == '0) && !after_d[3];
  // State and latched configuration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      dwell_q  <= '0;
      single_q <= 1'b0;
      cnt_q    <= '0;
      y_q      <= '0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      dwell_q  <= dwell_d;
      single_q <= single_d;
      cnt_q    <= cnt_d;
      y_q      <= y_d;
      pass_q   <= pass_d;
    end
  end
  // Next-state: start in IDLE, dwell countdown, channel advance and pass wrap; stop overrides all.
  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    dwell_d  = dwell_q;
    single_d = single_q;
    cnt_d    = cnt_q;
    y_d      = y_q;
    if (stop_i) begin
      state_d = IDLE;
      y_d     = '0;
    end else if (state_q == IDLE) begin
      if (start_i && first_i[3]) begin
        state_d  = DWELL;
        mask_d   = mask_i;
        dwell_d  = dwell_i;
        single_d = single_i;
        cnt_d    = reload(dwell_i);
        y_d      = first_i[2:0];
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - DWELL_W'(1);
    end else if (next_q[3]) begin
      y_d   = next_q[2:0];
      cnt_d = reload(dwell_q);
    end else if (single_q || !first_i[3]) begin
      state_d = IDLE;
      y_d     = '0;
      mask_d  = single_q ? mask_q : mask_i;
      dwell_d = single_q ? dwell_q : dwell_i;
    end else begin
      mask_d  = mask_i;
      dwell_d = dwell_i;
      cnt_d   = reload(dwell_i);
      y_d     = first_i[2:0];
    end
  end
  // Outputs come straight from registers.
  always_comb begin
    y_o         = y_q;
    y_valid_o   = (state_q == DWELL);
    busy_o      = (state_q == DWELL);
    pass_done_o = pass_q;
  end
endmodule
